// File: rtl/lift_dispatcher.sv
// Hall-call dispatcher for a two-car lift bank on floors 0..10: latches hall calls,
// assigns each one to the cheaper car by a distance/direction cost and issues a one-cycle floor request.
module lift_dispatcher (
    input  logic        clk,
    input  logic        rst,
    input  logic        hall_req_valid,
    input  logic [3:0]  hall_req_floor,
    output logic        hall_req_ready,
    output logic        hall_req_err,
    input  logic [1:0]  lift_en,
    input  logic [3:0]  lift0_floor,
    input  logic [3:0]  lift1_floor,
    input  logic [1:0]  lift0_motor,
    input  logic [1:0]  lift1_motor,
    output logic [3:0]  lift0_floorReq,
    output logic [3:0]  lift1_floorReq,
    output logic [10:0] hall_lamp,
    output logic [1:0]  dbg_state
);
    localparam int         NUM_FLOORS   = 11;
    localparam logic [4:0] AWAY_PENALTY = 5'd11;
    localparam logic [3:0] NO_REQ       = 4'b1111;

    typedef enum logic [1:0] {IDLE = 2'd0, PICK = 2'd1, COST = 2'd2, ISSUE = 2'd3} state_t;

    // Handshake: a call transfers on a rising edge where hall_req_valid && hall_req_ready;
    // ready is high whenever reset is released, so there is never back-pressure.
    state_t                  state, state_nxt;
    logic [NUM_FLOORS-1:0]   pending, assigned0, assigned1;
    logic [NUM_FLOORS-1:0]   pending_nxt, assigned0_nxt, assigned1_nxt;
    logic [NUM_FLOORS-1:0]   call_mask, tgt_mask, serve0_mask, serve1_mask;
    logic [3:0]              scan_ptr, target, pick_floor;
    logic                    winner, last_win, cost_win, any_en, accept, call_ok;
    logic [4:0]              cost0, cost1, idx;

    assign hall_req_ready = rst;
    assign accept         = hall_req_valid & hall_req_ready;
    assign call_ok        = accept && (hall_req_floor <= 4'd10);
    assign hall_lamp      = pending | assigned0 | assigned1;
    assign dbg_state      = state;
    assign any_en         = |lift_en;

    function automatic logic [4:0] car_cost(input logic [3:0] tgt, input logic [3:0] floor,
                                            input logic [1:0] motor);
        logic [4:0] c;
        c = (tgt >= floor) ? {1'b0, tgt - floor} : {1'b0, floor - tgt};
        if ((motor == 2'b11 && tgt < floor) || (motor == 2'b10 && tgt > floor))
            c = c + AWAY_PENALTY;
        return c;
    endfunction

    // Round-robin search: iterate downward so the lowest offset from scan_ptr wins.
    always_comb begin
        pick_floor = scan_ptr;
        idx        = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            idx = {1'b0, scan_ptr} + 5'(i);
            if (idx > 5'd10)
                idx = idx - 5'd11;
            if (pending[idx[3:0]])
                pick_floor = idx[3:0];
        end
    end

    always_comb begin
        cost0 = car_cost(target, lift0_floor, lift0_motor);
        cost1 = car_cost(target, lift1_floor, lift1_motor);
        if (lift_en == 2'b01)
            cost_win = 1'b0;
        else if (lift_en == 2'b10)
            cost_win = 1'b1;
        else if (cost0 < cost1)
            cost_win = 1'b0;
        else if (cost1 < cost0)
            cost_win = 1'b1;
        else
            cost_win = ~last_win;
    end

    // A shift past bit 10 yields zero, so out-of-range floors need no extra guard.
    always_comb begin
        call_mask   = call_ok ? (11'b1 << hall_req_floor) : '0;
        tgt_mask    = 11'b1 << target;
        serve0_mask = 11'b1 << lift0_floor;
        serve1_mask = 11'b1 << lift1_floor;

        pending_nxt   = pending | (call_mask & ~(assigned0 | assigned1));
        assigned0_nxt = assigned0 & ~serve0_mask;
        assigned1_nxt = assigned1 & ~serve1_mask;
        if (state == ISSUE) begin
            pending_nxt = pending_nxt & ~tgt_mask;
            if (winner)
                assigned1_nxt = assigned1_nxt | tgt_mask;
            else
                assigned0_nxt = assigned0_nxt | tgt_mask;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pending != '0 && any_en) state_nxt = PICK;
            PICK:    state_nxt = COST;
            COST:    state_nxt = any_en ? ISSUE : IDLE;
            ISSUE:   state_nxt = ((pending & ~tgt_mask) != '0) ? PICK : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            pending        <= '0;
            assigned0      <= '0;
            assigned1      <= '0;
            scan_ptr       <= '0;
            target         <= '0;
            winner         <= 1'b0;
            last_win       <= 1'b1;
            hall_req_err   <= 1'b0;
            lift0_floorReq <= NO_REQ;
            lift1_floorReq <= NO_REQ;
        end else begin
            state          <= state_nxt;
            pending        <= pending_nxt;
            assigned0      <= assigned0_nxt;
            assigned1      <= assigned1_nxt;
            hall_req_err   <= accept && (hall_req_floor > 4'd10);
            lift0_floorReq <= NO_REQ;
            lift1_floorReq <= NO_REQ;
            if (state == PICK)
                target <= pick_floor;
            // The request register loads on COST->ISSUE so it is live exactly during ISSUE.
            if (state == COST && any_en) begin
                winner <= cost_win;
                if (cost_win)
                    lift1_floorReq <= target;
                else
                    lift0_floorReq <= target;
            end
            if (state == ISSUE) begin
                last_win <= winner;
                scan_ptr <= (target >= 4'd10) ? 4'd0 : target + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_lift_dispatcher.sv
// Directed bench for lift_dispatcher: a scoreboard queue holds expected {car, floor}
// dispatches, popped whenever a floor request appears on either car.
module tb_lift_dispatcher;
    logic        clk = 1'b0;
    logic        rst;
    logic        hall_req_valid;
    logic [3:0]  hall_req_floor;
    logic        hall_req_ready;
    logic        hall_req_err;
    logic [1:0]  lift_en;
    logic [3:0]  lift0_floor, lift1_floor;
    logic [1:0]  lift0_motor, lift1_motor;
    logic [3:0]  lift0_floorReq, lift1_floorReq;
    logic [10:0] hall_lamp;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [4:0] exp_q[$];

    lift_dispatcher dut (
        .clk            (clk),
        .rst            (rst),
        .hall_req_valid (hall_req_valid),
        .hall_req_floor (hall_req_floor),
        .hall_req_ready (hall_req_ready),
        .hall_req_err   (hall_req_err),
        .lift_en        (lift_en),
        .lift0_floor    (lift0_floor),
        .lift1_floor    (lift1_floor),
        .lift0_motor    (lift0_motor),
        .lift1_motor    (lift1_motor),
        .lift0_floorReq (lift0_floorReq),
        .lift1_floorReq (lift1_floorReq),
        .hall_lamp      (hall_lamp),
        .dbg_state      (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then compare any floor request against the scoreboard.
    task automatic tick();
        logic [4:0] got;
        logic [4:0] want;
        @(posedge clk);
        #1;
        if (lift0_floorReq !== 4'hF || lift1_floorReq !== 4'hF) begin
            if (lift0_floorReq !== 4'hF && lift1_floorReq !== 4'hF)
                check("dual_req", {8'h00, lift0_floorReq, lift1_floorReq}, 16'h00FF);
            got = (lift1_floorReq !== 4'hF) ? {1'b1, lift1_floorReq} : {1'b0, lift0_floorReq};
            if (exp_q.size() == 0) begin
                check("unexpected_dispatch", 16'(got), 16'h001F);
            end else begin
                want = exp_q.pop_front();
                check("dispatch", 16'(got), 16'(want));
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_call(input logic [3:0] f);
        hall_req_valid = 1'b1;
        hall_req_floor = f;
        tick();
        hall_req_valid = 1'b0;
        hall_req_floor = 4'd0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ticks(2);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        hall_req_valid = 1'b0;
        hall_req_floor = 4'd0;
        lift_en = 2'b11;
        lift0_floor = 4'd0;  lift1_floor = 4'd0;
        lift0_motor = 2'b00; lift1_motor = 2'b00;
        ticks(2);
        check("rst_ready", 16'(hall_req_ready), 16'h0);
        check("rst_lamp", 16'(hall_lamp), 16'h0);
        check("rst_err", 16'(hall_req_err), 16'h0);
        check("rst_req0", 16'(lift0_floorReq), 16'hF);
        check("rst_req1", 16'(lift1_floorReq), 16'hF);
        check("rst_state", 16'(dbg_state), 16'h0);
        rst = 1'b1;
        #1;
        check("ready_up", 16'(hall_req_ready), 16'h1);

        // Single call, both cars idle at 0: tie goes to car 0.
        exp_q.push_back({1'b0, 4'd5});
        send_call(4'd5);
        check("s1_lamp", 16'(hall_lamp), 16'h0020);
        ticks(2);
        check("s1_pre_req", 16'(lift0_floorReq), 16'hF);
        tick();
        check("s1_req", 16'(lift0_floorReq), 16'h5);
        tick();
        check("s1_post_req", 16'(lift0_floorReq), 16'hF);
        check("s1_lamp_held", 16'(hall_lamp), 16'h0020);
        lift0_floor = 4'd5;
        tick();
        check("s1_lamp_clr", 16'(hall_lamp), 16'h0);

        // Cost: car1 moving down toward the call wins; moving away loses.
        lift0_floor = 4'd2; lift1_floor = 4'd7; lift1_motor = 2'b10;
        exp_q.push_back({1'b1, 4'd6});
        send_call(4'd6);
        ticks(4);
        lift1_floor = 4'd6;
        tick();
        check("s2a_lamp_clr", 16'(hall_lamp), 16'h0);
        lift1_floor = 4'd7; lift1_motor = 2'b11;
        exp_q.push_back({1'b0, 4'd6});
        send_call(4'd6);
        ticks(4);
        lift0_floor = 4'd6;
        tick();
        check("s2b_lamp_clr", 16'(hall_lamp), 16'h0);
        check("s2_q_empty", 16'(exp_q.size()), 16'h0);

        // Tie alternation from reset.
        do_reset();
        lift0_floor = 4'd3; lift1_floor = 4'd3; lift1_motor = 2'b00;
        exp_q.push_back({1'b0, 4'd5});
        send_call(4'd5);
        ticks(4);
        exp_q.push_back({1'b1, 4'd1});
        send_call(4'd1);
        ticks(4);
        lift0_floor = 4'd5; lift1_floor = 4'd1;
        tick();
        check("s3_lamp_clr", 16'(hall_lamp), 16'h0);
        check("s3_q_empty", 16'(exp_q.size()), 16'h0);

        // Round-robin and merge: 8, 2, 8 back-to-back with scan_ptr at 0.
        do_reset();
        lift0_floor = 4'd0; lift1_floor = 4'd10;
        exp_q.push_back({1'b0, 4'd2});
        exp_q.push_back({1'b1, 4'd8});
        send_call(4'd8);
        send_call(4'd2);
        send_call(4'd8);
        tick();
        check("s4_first", 16'(lift0_floorReq), 16'h2);
        ticks(2);
        check("s4_gap0", 16'(lift0_floorReq), 16'hF);
        check("s4_gap1", 16'(lift1_floorReq), 16'hF);
        tick();
        check("s4_second", 16'(lift1_floorReq), 16'h8);
        ticks(6);
        check("s4_q_empty", 16'(exp_q.size()), 16'h0);
        check("s4_lamp", 16'(hall_lamp), 16'h0104);
        check("s4_idle", 16'(dbg_state), 16'h0);
        lift0_floor = 4'd2; lift1_floor = 4'd8;
        tick();
        check("s4_lamp_clr", 16'(hall_lamp), 16'h0);

        // Out-of-range call is dropped with an error pulse.
        send_call(4'd12);
        check("s5_err", 16'(hall_req_err), 16'h1);
        check("s5_err_lamp", 16'(hall_lamp), 16'h0);
        tick();
        check("s5_err_clr", 16'(hall_req_err), 16'h0);
        check("s5_err_idle", 16'(dbg_state), 16'h0);

        // No car in service: call is held; enabling car1 dispatches it.
        lift_en = 2'b00;
        send_call(4'd4);
        ticks(5);
        check("s5_held_lamp", 16'(hall_lamp), 16'h0010);
        check("s5_held_idle", 16'(dbg_state), 16'h0);
        lift_en = 2'b10;
        exp_q.push_back({1'b1, 4'd4});
        ticks(3);
        check("s5_car1_req", 16'(lift1_floorReq), 16'h4);
        tick();
        lift1_floor = 4'd4;
        tick();
        check("s5_lamp_clr", 16'(hall_lamp), 16'h0);
        lift_en = 2'b11;

        // Reset asserted while in COST.
        send_call(4'd7);
        ticks(2);
        check("s6_in_cost", 16'(dbg_state), 16'h2);
        rst = 1'b0;
        #1;
        check("s6_rst_req0", 16'(lift0_floorReq), 16'hF);
        check("s6_rst_req1", 16'(lift1_floorReq), 16'hF);
        check("s6_rst_lamp", 16'(hall_lamp), 16'h0);
        check("s6_rst_ready", 16'(hall_req_ready), 16'h0);
        ticks(2);
        rst = 1'b1;
        ticks(6);
        check("s6_idle", 16'(dbg_state), 16'h0);
        check("s6_lamp", 16'(hall_lamp), 16'h0);

        check("final_q_empty", 16'(exp_q.size()), 16'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
